// File: rtl/parking_pkg.sv
// Shared parking constants: slot FSM state encoding and default sizing.
package parking_pkg;

   localparam int DEF_NUM_SLOTS = 4;
   localparam int DEF_CONFIRM_S = 3;
   localparam int DEF_CNT_W     = 4;

   localparam logic [1:0] S_EMPTY    = 2'd0;
   localparam logic [1:0] S_ARRIVING = 2'd1;
   localparam logic [1:0] S_OCCUPIED = 2'd2;
   localparam logic [1:0] S_LEAVING  = 2'd3;

endpackage

// File: rtl/slot_sensor_qualifier_if.sv
// Sensor-in / qualified-event-out bundle between the slot sensors, qualifier and timer.
interface slot_sensor_qualifier_if #(
   parameter int NUM_SLOTS = parking_pkg::DEF_NUM_SLOTS
);
   localparam int FREE_W = $clog2(NUM_SLOTS + 1);

   logic [NUM_SLOTS-1:0] sensor_raw;
   logic [NUM_SLOTS-1:0] car_entry;
   logic [NUM_SLOTS-1:0] car_exit;
   logic [NUM_SLOTS-1:0] occupied;
   logic [FREE_W-1:0]    free_count;
   logic                 lot_full;

   modport master (
      output sensor_raw,
      input  car_entry, car_exit, occupied, free_count, lot_full
   );

   modport slave (
      input  sensor_raw,
      output car_entry, car_exit, occupied, free_count, lot_full
   );
endinterface

// File: rtl/slot_qualifier_fsm.sv
// One slot: synchroniser, persistence FSM and registered entry/exit pulses.
//
// state    | meaning
// EMPTY    | no vehicle accepted, sensor low
// ARRIVING | sensor high, counting toward acceptance
// OCCUPIED | vehicle accepted, sensor high
// LEAVING  | sensor low, counting toward release
module slot_qualifier_fsm
   import parking_pkg::*;
#(
   parameter int CONFIRM_S = DEF_CONFIRM_S,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic clk_1Hz,
   input  logic reset,
   input  logic sensor_raw,
   output logic car_entry,
   output logic car_exit,
   output logic occupied
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONFIRM_S - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             sync_1, s;
   logic [1:0]       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             entry_nxt, exit_nxt;

   always_ff @(posedge clk_1Hz or posedge reset) begin
      if (reset) begin
         sync_1    <= 1'b0;
         s         <= 1'b0;
         state     <= S_EMPTY;
         cnt       <= '0;
         car_entry <= 1'b0;
         car_exit  <= 1'b0;
      end else begin
         sync_1    <= sensor_raw;
         s         <= sync_1;
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         car_entry <= entry_nxt;
         car_exit  <= exit_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      case (state)
         S_EMPTY: if (s) begin
            state_nxt = S_ARRIVING;
            cnt_nxt   = CNT_ONE;
         end
         S_ARRIVING: begin
            if (!s)                   state_nxt = S_EMPTY;
            else if (cnt == CNT_LAST) state_nxt = S_OCCUPIED;
            else                      cnt_nxt   = cnt + CNT_ONE;
         end
         S_OCCUPIED: if (!s) begin
            state_nxt = S_LEAVING;
            cnt_nxt   = CNT_ONE;
         end
         S_LEAVING: begin
            if (s)                    state_nxt = S_OCCUPIED;
            else if (cnt == CNT_LAST) state_nxt = S_EMPTY;
            else                      cnt_nxt   = cnt + CNT_ONE;
         end
         default: state_nxt = S_EMPTY;
      endcase
   end

   always_comb begin
      entry_nxt = (state == S_ARRIVING) &&  s && (cnt == CNT_LAST);
      exit_nxt  = (state == S_LEAVING)  && !s && (cnt == CNT_LAST);
   end

   // OCCUPIED and LEAVING share the upper encoding bit, so this is a flop output
   assign occupied = state[1];
endmodule

// File: rtl/slot_sensor_qualifier.sv
// Per-slot sensor qualification plus lot-level free count and full flag.
module slot_sensor_qualifier
   import parking_pkg::*;
#(
   parameter int NUM_SLOTS = DEF_NUM_SLOTS,
   parameter int CONFIRM_S = DEF_CONFIRM_S,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic                  clk_1Hz,
   input  logic                  reset,
   slot_sensor_qualifier_if.slave bus
);
   localparam int FREE_W = $clog2(NUM_SLOTS + 1);

   logic [NUM_SLOTS-1:0] entry_w, exit_w, occ_w;
   logic [FREE_W-1:0]    occ_cnt;

   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      slot_qualifier_fsm #(
         .CONFIRM_S(CONFIRM_S),
         .CNT_W    (CNT_W)
      ) u_slot (
         .clk_1Hz   (clk_1Hz),
         .reset     (reset),
         .sensor_raw(bus.sensor_raw[i]),
         .car_entry (entry_w[i]),
         .car_exit  (exit_w[i]),
         .occupied  (occ_w[i])
      );
   end

   always_comb begin
      occ_cnt = '0;
      for (int i = 0; i < NUM_SLOTS; i++) occ_cnt = occ_cnt + FREE_W'(occ_w[i]);
   end

   assign bus.car_entry  = entry_w;
   assign bus.car_exit   = exit_w;
   assign bus.occupied   = occ_w;
   assign bus.free_count = FREE_W'(NUM_SLOTS) - occ_cnt;
   assign bus.lot_full   = (bus.free_count == '0);
endmodule

// File: tb/tb_slot_sensor_qualifier.sv
// Directed bench for slot_sensor_qualifier with hand-computed pulse timing.
module tb_slot_sensor_qualifier;
   logic clk_1Hz = 1'b0;
   logic reset   = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   slot_sensor_qualifier_if #(.NUM_SLOTS(4)) bus ();

   slot_sensor_qualifier #(.NUM_SLOTS(4), .CONFIRM_S(3), .CNT_W(4)) dut (
      .clk_1Hz(clk_1Hz),
      .reset  (reset),
      .bus    (bus)
   );

   always #5 clk_1Hz = ~clk_1Hz;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(negedge clk_1Hz);
   endtask

   // Runs n cycles; pulses must appear only in cycle 'hit' (0 = never).
   task automatic watch(input int n, input int hit, input logic [3:0] exp_en, input logic [3:0] exp_ex);
      for (int j = 1; j <= n; j++) begin
         cyc();
         check($sformatf("car_entry c%0d", j), 32'(bus.car_entry), (j == hit) ? 32'(exp_en) : 32'd0);
         check($sformatf("car_exit c%0d", j),  32'(bus.car_exit),  (j == hit) ? 32'(exp_ex) : 32'd0);
      end
   endtask

   task automatic check_lot(input string tag, input logic [3:0] occ, input int free, input logic full);
      check({tag, " occupied"},   32'(bus.occupied),   32'(occ));
      check({tag, " free_count"}, 32'(bus.free_count), 32'(free));
      check({tag, " lot_full"},   32'(bus.lot_full),   32'(full));
   endtask

   initial begin
      int n_en, n_ex, c_en, c_ex;
      bus.sensor_raw = 4'b0000;
      repeat (3) cyc();
      check_lot("in reset", 4'b0000, 4, 1'b0);
      reset = 1'b0;

      // idle
      watch(10, 0, 4'b0000, 4'b0000);
      check_lot("idle", 4'b0000, 4, 1'b0);

      // slot 0 arrives
      bus.sensor_raw = 4'b0001;
      watch(6, 5, 4'b0001, 4'b0000);
      check_lot("slot0 in", 4'b0001, 3, 1'b0);

      // 2-cycle glitch on empty slot 1
      bus.sensor_raw = 4'b0011;
      repeat (2) cyc();
      bus.sensor_raw = 4'b0001;
      watch(8, 0, 4'b0000, 4'b0000);
      check_lot("glitch high", 4'b0001, 3, 1'b0);

      // slot 1 arrives, then a 2-cycle dropout
      bus.sensor_raw = 4'b0011;
      watch(6, 5, 4'b0010, 4'b0000);
      bus.sensor_raw = 4'b0001;
      repeat (2) cyc();
      bus.sensor_raw = 4'b0011;
      watch(8, 0, 4'b0000, 4'b0000);
      check_lot("glitch low", 4'b0011, 2, 1'b0);

      // empty the lot, then fill all four at once
      bus.sensor_raw = 4'b0000;
      watch(6, 5, 4'b0000, 4'b0011);
      check_lot("emptied", 4'b0000, 4, 1'b0);
      bus.sensor_raw = 4'b1111;
      watch(6, 5, 4'b1111, 4'b0000);
      check_lot("full", 4'b1111, 0, 1'b1);
      bus.sensor_raw = 4'b0011;
      watch(6, 5, 4'b0000, 4'b1100);
      check_lot("2,3 out", 4'b0011, 2, 1'b0);

      // leave only slot 0, then reset with its sensor still high
      bus.sensor_raw = 4'b0001;
      watch(6, 5, 4'b0000, 4'b0010);
      reset = 1'b1;
      #1;
      check_lot("async reset", 4'b0000, 4, 1'b0);
      check("reset car_entry", 32'(bus.car_entry), 32'd0);
      cyc();
      reset = 1'b0;
      watch(6, 5, 4'b0001, 4'b0000);
      check_lot("requalified", 4'b0001, 3, 1'b0);

      // slot 3 stays 20 s
      n_en = 0; n_ex = 0; c_en = 0; c_ex = 0;
      bus.sensor_raw = 4'b1001;
      for (int j = 1; j <= 40; j++) begin
         cyc();
         if (bus.car_entry[3]) begin n_en++; c_en = j; end
         if (bus.car_exit[3])  begin n_ex++; c_ex = j; end
         if (j == 20) bus.sensor_raw = 4'b0001;
      end
      check("slot3 entry pulses", 32'(n_en), 32'd1);
      check("slot3 exit pulses",  32'(n_ex), 32'd1);
      check("slot3 entry cycle",  32'(c_en), 32'd5);
      check("slot3 elapsed",      32'(c_ex - c_en), 32'd20);
      check_lot("slot3 gone", 4'b0001, 3, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
